// File: rtl/dpram_pkg.sv
// Shared constants, FSM encoding and byte-merge helper for the parametrised
// true-dual-port RAM.
package dpram_pkg;

    localparam int WM_WRITE_FIRST = 0;
    localparam int WM_READ_FIRST  = 1;
    localparam int WM_NO_CHANGE   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Returns the new byte where its enable is set, the old byte otherwise.
    function automatic logic [7:0] merge_byte(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       be
    );
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/dpram_tdp_param_if.sv
// Bus bundle for both RAM ports plus the clear/collision side-band signals.
// master drives requests, slave is the RAM.
interface dpram_tdp_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic                  CLEAR;
    logic                  BUSY;

    logic                  WEN_A;
    logic [DATA_W/8-1:0]   BE_A;
    logic                  REN_A;
    logic [ADDR_W-1:0]     ADDR_A;
    logic [DATA_W-1:0]     DATA_IN_A;
    logic [DATA_W-1:0]     DATA_OUT_A;
    logic                  VALID_A;

    logic                  WEN_B;
    logic [DATA_W/8-1:0]   BE_B;
    logic                  REN_B;
    logic [ADDR_W-1:0]     ADDR_B;
    logic [DATA_W-1:0]     DATA_IN_B;
    logic [DATA_W-1:0]     DATA_OUT_B;
    logic                  VALID_B;

    logic                  COLLISION;

    modport master (
        output CLEAR,
        output WEN_A, BE_A, REN_A, ADDR_A, DATA_IN_A,
        output WEN_B, BE_B, REN_B, ADDR_B, DATA_IN_B,
        input  BUSY, DATA_OUT_A, VALID_A, DATA_OUT_B, VALID_B, COLLISION
    );

    modport slave (
        input  CLEAR,
        input  WEN_A, BE_A, REN_A, ADDR_A, DATA_IN_A,
        input  WEN_B, BE_B, REN_B, ADDR_B, DATA_IN_B,
        output BUSY, DATA_OUT_A, VALID_A, DATA_OUT_B, VALID_B, COLLISION
    );
endinterface

// File: rtl/dpram_clear_seq.sv
// Clear sequencer: sweeps every address once with INIT_VAL after reset release
// or on a CLEAR request, holding busy high for exactly DEPTH cycles.
module dpram_clear_seq
    import dpram_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              busy,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              sweep_we
);
    // One extra bit so the end of the sweep shows up as the count DEPTH.
    localparam logic [ADDR_W:0] CNT_END   = {1'b1, {ADDR_W{1'b0}}};
    localparam state_t          RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == CNT_END) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy       = (state_q == ST_CLEAR);
    assign sweep_we   = busy;
    assign sweep_addr = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/dpram_tdp_param.sv
// Single-clock true-dual-port RAM with byte enables, selectable write mode,
// optional output register, collision flag and a built-in clear sweep.
module dpram_tdp_param
    import dpram_pkg::*;
#(
    parameter int                 DATA_W         = 16,
    parameter int                 ADDR_W         = 8,
    parameter int                 OUT_REG        = 0,
    parameter int                 WRITE_MODE     = WM_WRITE_FIRST,
    parameter logic [DATA_W-1:0]  INIT_VAL       = '1,
    parameter int                 CLEAR_ON_RESET = 1
) (
    input  logic              CLK,
    input  logic              RST,
    dpram_tdp_param_if.slave  bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic              busy;
    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;

    dpram_clear_seq #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk        (CLK),
        .rst        (RST),
        .clear_req  (bus.CLEAR),
        .busy       (busy),
        .sweep_addr (sweep_addr),
        .sweep_we   (sweep_we)
    );

    assign bus.BUSY = busy;

    // Index 0 is port A, index 1 is port B.
    logic              wen_usr [2];
    logic              ren_usr [2];
    logic [BE_W-1:0]   be_p    [2];
    logic [ADDR_W-1:0] addr_p  [2];
    logic [DATA_W-1:0] din_p   [2];
    logic [DATA_W-1:0] dout_p  [2];
    logic              valid_p [2];

    assign wen_usr[0] = !busy && bus.WEN_A;
    assign ren_usr[0] = !busy && bus.REN_A;
    assign be_p[0]    = bus.BE_A;
    assign addr_p[0]  = bus.ADDR_A;
    assign din_p[0]   = bus.DATA_IN_A;

    assign wen_usr[1] = !busy && bus.WEN_B;
    assign ren_usr[1] = !busy && bus.REN_B;
    assign be_p[1]    = bus.BE_B;
    assign addr_p[1]  = bus.ADDR_B;
    assign din_p[1]   = bus.DATA_IN_B;

    // The sweep borrows the port B write path while busy.
    logic              mem_we_a;
    logic              mem_we_b;
    logic [ADDR_W-1:0] mem_addr_b;
    logic [DATA_W-1:0] mem_din_b;
    logic [BE_W-1:0]   mem_be_b;

    always_comb begin
        mem_we_a = wen_usr[0] && !RST;
        if (busy) begin
            mem_we_b   = sweep_we && !RST;
            mem_addr_b = sweep_addr;
            mem_din_b  = INIT_VAL;
            mem_be_b   = '1;
        end else begin
            mem_we_b   = wen_usr[1] && !RST;
            mem_addr_b = addr_p[1];
            mem_din_b  = din_p[1];
            mem_be_b   = be_p[1];
        end
    end

    logic [DATA_W-1:0] mem [DEPTH];

    // Port A is applied last so its enabled bytes win an address clash.
    always_ff @(posedge CLK) begin
        for (int b = 0; b < BE_W; b++) begin
            if (mem_we_b && mem_be_b[b]) begin
                mem[mem_addr_b][b*8 +: 8] <= mem_din_b[b*8 +: 8];
            end
            if (mem_we_a && be_p[0][b]) begin
                mem[addr_p[0]][b*8 +: 8] <= din_p[0][b*8 +: 8];
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic              rd_acc;
        logic [DATA_W-1:0] rd_word;
        logic [DATA_W-1:0] s1_data_d;
        logic [DATA_W-1:0] s1_data_q;
        logic              s1_valid_q;

        // Only the port's own write is merged; the other port's write is never seen.
        always_comb begin
            rd_acc  = ren_usr[gi] && !(WRITE_MODE == WM_NO_CHANGE && wen_usr[gi]);
            rd_word = '0;
            for (int b = 0; b < BE_W; b++) begin
                rd_word[b*8 +: 8] = merge_byte(mem[addr_p[gi]][b*8 +: 8],
                                               din_p[gi][b*8 +: 8],
                                               (WRITE_MODE == WM_WRITE_FIRST) &&
                                               wen_usr[gi] && be_p[gi][b]);
            end
            s1_data_d = rd_acc ? rd_word : s1_data_q;
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                s1_data_q  <= '0;
                s1_valid_q <= 1'b0;
            end else begin
                s1_data_q  <= s1_data_d;
                s1_valid_q <= rd_acc;
            end
        end

        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] s2_data_d;
            logic [DATA_W-1:0] s2_data_q;
            logic              s2_valid_q;

            assign s2_data_d = s1_valid_q ? s1_data_q : s2_data_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    s2_data_q  <= '0;
                    s2_valid_q <= 1'b0;
                end else begin
                    s2_data_q  <= s2_data_d;
                    s2_valid_q <= s1_valid_q;
                end
            end

            assign dout_p[gi]  = s2_data_q;
            assign valid_p[gi] = s2_valid_q;
        end else begin : g_noreg
            assign dout_p[gi]  = s1_data_q;
            assign valid_p[gi] = s1_valid_q;
        end
    end

    assign bus.DATA_OUT_A = dout_p[0];
    assign bus.VALID_A    = valid_p[0];
    assign bus.DATA_OUT_B = dout_p[1];
    assign bus.VALID_B    = valid_p[1];

    logic col1_d;
    logic col1_q;

    assign col1_d = wen_usr[0] && wen_usr[1] && (addr_p[0] == addr_p[1]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            col1_q <= 1'b0;
        end else begin
            col1_q <= col1_d;
        end
    end

    if (OUT_REG != 0) begin : g_col_oreg
        logic col2_q;
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                col2_q <= 1'b0;
            end else begin
                col2_q <= col1_q;
            end
        end
        assign bus.COLLISION = col2_q;
    end else begin : g_col_noreg
        assign bus.COLLISION = col1_q;
    end

endmodule
